// File: rtl/branch_redirect_ctrl.sv
// PC redirection sequencer: 2-bit BHT prediction in IF, EX-stage mispredict/jump detection,
// one-cycle registered redirect followed by a fixed-length flush, plus saturating statistics.
module branch_redirect_ctrl #(
    parameter int unsigned BHT_ENTRIES  = 16,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned XLEN         = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    input  logic            if_is_branch,
    input  logic [XLEN-1:0] if_imm,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            stall,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [15:0]     stat_branches,
    output logic [15:0]     stat_mispred
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [2:0]  FlushInit = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              redirect_q, redirect_d;
    logic              flush_q, flush_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
    logic [15:0]       stat_branches_q, stat_branches_d;
    logic [15:0]       stat_mispred_q, stat_mispred_d;
    logic [1:0]        bht_q [BHT_ENTRIES];
    logic [1:0]        bht_d [BHT_ENTRIES];

    logic [IDX_W-1:0]  if_idx, ex_idx;
    logic              resolve, mis, bht_upd;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // BHT read is the registered value only; same-cycle updates are not bypassed.
    assign pred_taken  = if_is_branch & bht_q[if_idx][1];
    assign pred_target = if_pc + if_imm;

    assign resolve = ex_valid & ~stall & (state_q == StIdle);
    assign mis     = resolve & (ex_jump | (ex_branch & (ex_taken != ex_pred_taken)));
    assign bht_upd = resolve & ex_branch & ~ex_jump;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        redirect_d      = 1'b0;
        flush_d         = flush_q;
        redirect_pc_d   = redirect_pc_q;
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        bht_d           = bht_q;

        case (state_q)
            StIdle: begin
                flush_d = 1'b0;
                if (mis) begin
                    state_d       = StFlush;
                    cnt_d         = FlushInit;
                    redirect_d    = 1'b1;
                    flush_d       = 1'b1;
                    redirect_pc_d = ex_taken ? ex_target : ex_pc + XLEN'(4);
                end
            end
            StFlush: begin
                flush_d = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = StIdle;
                    flush_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (bht_upd) begin
            if (ex_taken) begin
                if (bht_q[ex_idx] != 2'b11) bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
            end else begin
                if (bht_q[ex_idx] != 2'b00) bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
            end
            if (stat_branches_q != 16'hFFFF) stat_branches_d = stat_branches_q + 16'd1;
        end

        if (mis && stat_mispred_q != 16'hFFFF) stat_mispred_d = stat_mispred_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            cnt_q           <= 3'd0;
            redirect_q      <= 1'b0;
            flush_q         <= 1'b0;
            redirect_pc_q   <= '0;
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            redirect_q      <= redirect_d;
            flush_q         <= flush_d;
            redirect_pc_q   <= redirect_pc_d;
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
            bht_q           <= bht_d;
        end
    end

    assign redirect      = redirect_q;
    assign redirect_pc   = redirect_pc_q;
    assign flush         = flush_q;
    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;

endmodule
